// File: rtl/speed_sequencer_if.sv
// rtl/speed_sequencer_if.sv - program-write, control and divider signals of speed_sequencer
//
// Signals (direction as seen by the sequencer, slave modport):
//   WrEn, WrAddr[AW], WrSpeed[2], WrDur[DUR_W]  in   program-table write
//   Start, Pause, Abort                          in   user control levels
//   Tick                                         in   divider Enable pulse
//   Speed[2]                                     out  divider speed select
//   DivReset                                     out  divider phase restart request
//   Busy, Done                                   out  sequencing status
//   Step[AW]                                     out  current program entry
// The master modport is the driver side (controller logic or testbench).
interface speed_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int DUR_W = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             WrEn;
    logic [AW-1:0]    WrAddr;
    logic [1:0]       WrSpeed;
    logic [DUR_W-1:0] WrDur;
    logic             Start;
    logic             Pause;
    logic             Abort;
    logic             Tick;
    logic [1:0]       Speed;
    logic             DivReset;
    logic             Busy;
    logic             Done;
    logic [AW-1:0]    Step;

    modport master (
        output WrEn, WrAddr, WrSpeed, WrDur, Start, Pause, Abort, Tick,
        input  Speed, DivReset, Busy, Done, Step
    );

    modport slave (
        input  WrEn, WrAddr, WrSpeed, WrDur, Start, Pause, Abort, Tick,
        output Speed, DivReset, Busy, Done, Step
    );
endinterface

// File: rtl/speed_sequencer.sv
// rtl/speed_sequencer.sv - segment program sequencer driving the rate divider speed select
//
// Steps through DEPTH {speed, duration} entries. Each entry is loaded in a
// one-cycle LOAD state that restarts the divider phase (DivReset), then RUN
// counts divider Ticks until the duration is used up. Pause freezes counting;
// release restarts the divider phase without reloading the entry.
// Ports:
//   ClockIn  in   system clock, rising edge
//   Reset    in   synchronous active-high reset, also clears the program table
//   bus      slave modport of speed_sequencer_if:
//            WrEn/WrAddr/WrSpeed/WrDur table write, Start/Pause/Abort control,
//            Tick from divider; Speed, DivReset, Busy, Done, Step outputs
// Build option: SPEED_SEQ_LOOP_EN - when defined the program repeats from
// entry 0 instead of stopping in DONE.
module speed_sequencer #(
    parameter int DEPTH = 4,
    parameter int DUR_W = 4
) (
    input  logic             ClockIn,
    input  logic             Reset,
    speed_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    // S_RESUME is the divider restart after a pause: DivReset like LOAD, but no reload.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSED,
        S_RESUME,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    step_q, step_d;
    logic [1:0]       speed_q, speed_d;
    logic [DUR_W-1:0] remain_q, remain_d;
    logic [1:0]       spd_tab_q [DEPTH];
    logic [1:0]       spd_tab_d [DEPTH];
    logic [DUR_W-1:0] dur_tab_q [DEPTH];
    logic [DUR_W-1:0] dur_tab_d [DEPTH];
    logic             seg_done;
    logic             last_step;

    assign last_step = (step_q == AW'(DEPTH - 1));

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        speed_d   = speed_q;
        remain_d  = remain_q;
        spd_tab_d = spd_tab_q;
        dur_tab_d = dur_tab_q;
        seg_done  = 1'b0;

        // Table writes land in every state; the running segment already holds
        // its own copy in remain_q/speed_q, so it is unaffected.
        if (bus.WrEn) begin
            spd_tab_d[bus.WrAddr] = bus.WrSpeed;
            dur_tab_d[bus.WrAddr] = bus.WrDur;
        end

        if (bus.Abort) begin
            state_d = S_IDLE;
            step_d  = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.Start) begin
                        state_d = S_LOAD;
                        step_d  = '0;
                    end
                end
                S_LOAD: begin
                    speed_d  = spd_tab_q[step_q];
                    remain_d = dur_tab_q[step_q];
                    if (dur_tab_q[step_q] != '0) begin
                        state_d = S_RUN;
                    end else begin
                        seg_done = 1'b1;
                    end
                end
                S_RUN: begin
                    // Pause wins over a coincident Tick, which is dropped.
                    if (bus.Pause) begin
                        state_d = S_PAUSED;
                    end else if (bus.Tick) begin
                        if (remain_q > DUR_W'(1)) begin
                            remain_d = remain_q - DUR_W'(1);
                        end else begin
                            seg_done = 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.Pause) begin
                        state_d = S_RESUME;
                    end
                end
                S_RESUME: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (seg_done) begin
                if (last_step) begin
`ifdef SPEED_SEQ_LOOP_EN
                    state_d = S_LOAD;
                    step_d  = '0;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOAD;
                    step_d  = step_q + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            speed_q  <= '0;
            remain_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                spd_tab_q[i] <= '0;
                dur_tab_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            speed_q   <= speed_d;
            remain_q  <= remain_d;
            spd_tab_q <= spd_tab_d;
            dur_tab_q <= dur_tab_d;
        end
    end

    assign bus.Speed    = speed_q;
    assign bus.Step     = step_q;
    assign bus.DivReset = (state_q == S_LOAD) || (state_q == S_RESUME);
    assign bus.Busy     = (state_q == S_LOAD) || (state_q == S_RUN) ||
                          (state_q == S_PAUSED) || (state_q == S_RESUME);
    assign bus.Done     = (state_q == S_DONE);
endmodule

// File: tb/tb_speed_sequencer.sv
// tb/tb_speed_sequencer.sv - self-checking bench for speed_sequencer
module tb_speed_sequencer;
    localparam int DEPTH = 4;
    localparam int DUR_W = 4;
    localparam int MAXC  = 310;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    speed_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();
    speed_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
        .ClockIn (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Bench copy of the program table.
    logic [1:0] p_spd [DEPTH];
    logic [3:0] p_dur [DEPTH];

    // Per-cycle stimulus and traces; vector = {Busy, Done, DivReset, Step[1:0], Speed[1:0]}.
    bit         tick_pat  [MAXC];
    bit         pause_pat [MAXC];
    logic [6:0] exp_v     [MAXC];
    logic [6:0] obs_v     [MAXC];

    int         wr_c    = -1;
    int         abort_c = -1;
    logic [1:0] wr_a, wr_s;
    logic [3:0] wr_d;
    logic [1:0] cur_speed;

    // Segment timeline model: Start seen at the end of cycle 0, LOAD in cycle 1.
    // Walks entries, counting ticks and skipping paused stretches.
    function automatic void build_model(int n, logic [1:0] spd0);
        int t, c, k, rem;
        bit fin;
        logic [1:0] spd;
        spd = spd0;
        t   = 1;
        fin = 0;
        while (!fin && t <= n) begin
            for (int i = 0; i < DEPTH && t <= n; i++) begin
                exp_v[t] = {3'b101, 2'(i), spd};
                spd = p_spd[i];
                c   = t + 1;
                rem = int'(p_dur[i]);
                while (rem > 0 && c <= n) begin
                    exp_v[c] = {3'b100, 2'(i), spd};
                    if (pause_pat[c]) begin
                        k = c + 1;
                        while (k <= n && pause_pat[k]) begin
                            exp_v[k] = {3'b100, 2'(i), spd};
                            k++;
                        end
                        if (k <= n)     exp_v[k]     = {3'b100, 2'(i), spd};
                        if (k + 1 <= n) exp_v[k + 1] = {3'b101, 2'(i), spd};
                        c = k + 2;
                    end else begin
                        if (tick_pat[c]) rem--;
                        c++;
                    end
                end
                t = c;
            end
`ifdef SPEED_SEQ_LOOP_EN
            fin = 0;
`else
            fin = 1;
`endif
        end
        for (int x = t; x <= n; x++) exp_v[x] = {3'b010, 2'(DEPTH - 1), spd};
    endfunction

    task automatic idle_inputs();
        bus.WrEn = 0; bus.WrAddr = '0; bus.WrSpeed = '0; bus.WrDur = '0;
        bus.Start = 0; bus.Pause = 0; bus.Abort = 0; bus.Tick = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(int a, logic [1:0] s, logic [3:0] d);
        bus.WrEn = 1; bus.WrAddr = 2'(a); bus.WrSpeed = s; bus.WrDur = d;
        cyc();
        bus.WrEn = 0;
        p_spd[a] = s;
        p_dur[a] = d;
    endtask

    task automatic set_ticks(int per);
        for (int c = 0; c < MAXC; c++) begin
            tick_pat[c]  = (c % per == 0);
            pause_pat[c] = 0;
        end
    endtask

    // Pulses Start in the current cycle, then records n cycles of outputs.
    task automatic run_seq(int n);
        bus.Start = 1; bus.Tick = 0; bus.Pause = 0;
        for (int c = 1; c <= n; c++) begin
            cyc();
            obs_v[c]    = {bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed};
            bus.Start   = 0;
            bus.Tick    = tick_pat[c];
            bus.Pause   = pause_pat[c];
            bus.Abort   = (c == abort_c);
            bus.WrEn    = (c == wr_c);
            bus.WrAddr  = wr_a;
            bus.WrSpeed = wr_s;
            bus.WrDur   = wr_d;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        cyc(); cyc();
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs got %b exp %b", {bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed}, 7'b0);
        end
        rst = 0;
        cyc(); cyc();
        n_cmp++;
        if ({bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed} !== 7'b0) begin
            n_err++;
            $display("FAIL idle_after_reset got %b exp %b", {bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed}, 7'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin p_spd[i] = 0; p_dur[i] = 0; end
        cur_speed = 0;
    endtask

    task automatic test_program();
        logic [1:0] seen[$];
        int divs;
        prog_write(0, 2'b01, 4'd3); prog_write(1, 2'b10, 4'd2);
        prog_write(2, 2'b11, 4'd1); prog_write(3, 2'b00, 4'd0);
        set_ticks(4);
        build_model(60, cur_speed);
        run_seq(60);
        for (int c = 1; c <= 60; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL program_trace c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        divs = 0;
        for (int c = 1; c <= 60; c++) begin
            if (obs_v[c][4]) divs++;
            if (obs_v[c][6] && !obs_v[c][4] && (seen.size() == 0 || seen[$] != obs_v[c][1:0]))
                seen.push_back(obs_v[c][1:0]);
        end
        n_cmp++;
        if (divs != DEPTH) begin
            n_err++;
            $display("FAIL program_divreset_count got %0d exp %0d", divs, DEPTH);
        end
        n_cmp++;
        if (seen.size() != 3 || seen[0] != 2'b01 || seen[1] != 2'b10 || seen[2] != 2'b11) begin
            n_err++;
            $display("FAIL program_speed_order got %p exp 1 2 3", seen);
        end
        cur_speed = exp_v[60][1:0];
    endtask

    task automatic test_pause();
        int pst, divs;
        set_ticks(2);
        build_model(60, cur_speed);
        pst = -1;
        for (int c = 60; c >= 1; c--)
            if (exp_v[c][6] && !exp_v[c][4] && exp_v[c][3:2] == 2'd1) pst = c;
        for (int c = pst + 1; c <= pst + 10; c++) pause_pat[c] = 1;
        build_model(60, cur_speed);
        run_seq(60);
        for (int c = 1; c <= 60; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL pause_trace c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        divs = 0;
        for (int c = 1; c <= 60; c++) if (obs_v[c][4]) divs++;
        n_cmp++;
        if (divs != DEPTH + 1) begin
            n_err++;
            $display("FAIL pause_divreset_count got %0d exp %0d", divs, DEPTH + 1);
        end
        cur_speed = exp_v[60][1:0];
    endtask

    task automatic test_abort();
        set_ticks(3);
        build_model(50, cur_speed);
        for (int c = 50; c >= 1; c--)
            if (exp_v[c][6] && !exp_v[c][4] && exp_v[c][3:2] == 2'd1) abort_c = c;
        for (int c = abort_c + 1; c <= 50; c++) exp_v[c] = {5'b00000, exp_v[abort_c][1:0]};
        run_seq(50);
        for (int c = 1; c <= 50; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL abort_trace c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        n_cmp++;
        if (obs_v[abort_c + 1] !== {5'b00000, p_spd[1]}) begin
            n_err++;
            $display("FAIL abort_next_cycle got %b exp %b", obs_v[abort_c + 1], {5'b00000, p_spd[1]});
        end
        abort_c = -1;
        cur_speed = p_spd[1];
        build_model(50, cur_speed);
        run_seq(50);
        for (int c = 1; c <= 50; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL abort_replay c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        n_cmp++;
        if (obs_v[2][3:0] !== {2'd0, p_spd[0]}) begin
            n_err++;
            $display("FAIL abort_replay_entry0 got %b exp %b", obs_v[2][3:0], {2'd0, p_spd[0]});
        end
        cur_speed = exp_v[50][1:0];
    endtask

    task automatic test_write_during_run();
        set_ticks(2);
        build_model(60, cur_speed);
        for (int c = 60; c >= 1; c--)
            if (exp_v[c][6] && !exp_v[c][4] && exp_v[c][3:2] == 2'd1) wr_c = c;
        wr_a = 2'd1; wr_s = 2'b11; wr_d = 4'd5;
        run_seq(60);
        for (int c = 1; c <= 60; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL write_old_dur c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        wr_c = -1;
        p_spd[1] = 2'b11; p_dur[1] = 4'd5;
        cur_speed = exp_v[60][1:0];
        build_model(60, cur_speed);
        run_seq(60);
        for (int c = 1; c <= 60; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL write_new_entry c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        cur_speed = exp_v[60][1:0];
    endtask

    task automatic test_all_zero();
        int divs;
        for (int i = 0; i < DEPTH; i++) prog_write(i, 2'(i), 4'd0);
        set_ticks(1);
        build_model(12, cur_speed);
        run_seq(12);
        for (int c = 1; c <= 12; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL all_zero_trace c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        divs = 0;
        for (int c = 1; c <= DEPTH; c++) if (obs_v[c][4] && obs_v[c][6]) divs++;
        n_cmp++;
        if (divs != DEPTH) begin
            n_err++;
            $display("FAIL all_zero_loads got %0d exp %0d", divs, DEPTH);
        end
        cur_speed = exp_v[12][1:0];
    endtask

    task automatic test_reset_midrun();
        bit found;
        prog_write(0, 2'b01, 4'd3); prog_write(1, 2'b10, 4'd2);
        bus.Start = 1;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            cyc();
            if (bus.Busy && !bus.DivReset) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_midrun_reach_run got 0 exp 1");
        end
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            n_cmp++;
            if ({bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_midrun_hold c=%0d got %b exp %b", c, {bus.Busy, bus.Done, bus.DivReset, bus.Step, bus.Speed}, 7'b0);
            end
        end
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin p_spd[i] = 0; p_dur[i] = 0; end
        cur_speed = 0;
        set_ticks(1);
        build_model(10, cur_speed);
        run_seq(10);
        for (int c = 1; c <= 10; c++) begin
            n_cmp++;
            if (obs_v[c] !== exp_v[c]) begin
                n_err++;
                $display("FAIL reset_cleared_table c=%0d got %b exp %b", c, obs_v[c], exp_v[c]);
            end
        end
        cur_speed = exp_v[10][1:0];
    endtask

    task automatic test_random();
        int burst;
        for (int it = 0; it < 5; it++) begin
            for (int i = 0; i < DEPTH; i++)
                prog_write(i, 2'($urandom_range(0, 3)),
                           ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
            burst = 0;
            for (int c = 0; c < MAXC; c++) begin
                tick_pat[c] = (c >= 200) ? 1'b1 : ($urandom_range(0, 2) != 0);
                if (burst > 0) begin
                    pause_pat[c] = 1; burst--;
                end else if (c < 150 && $urandom_range(0, 19) == 0) begin
                    pause_pat[c] = 1; burst = $urandom_range(0, 5);
                end else begin
                    pause_pat[c] = 0;
                end
            end
            build_model(300, cur_speed);
            run_seq(300);
            for (int c = 1; c <= 300; c++) begin
                n_cmp++;
                if (obs_v[c] !== exp_v[c]) begin
                    n_err++;
                    $display("FAIL random_trace it=%0d c=%0d got %b exp %b", it, c, obs_v[c], exp_v[c]);
                end
            end
            cur_speed = exp_v[300][1:0];
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_program();
        test_pause();
        test_abort();
        test_write_during_run();
        test_all_zero();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
